// File: rtl/market_pkg.sv
// market_pkg: shared types and constants for market_update_scheduler.
//   state_t     - scheduler FSM states (IDLE, REQ, CALC, WRITE)
//   DEF_*       - default parameter values
//   init_price  - reset price, the midpoint of the legal price range
package market_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    CALC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam int DEF_NUM_STOCKS  = 4;
  localparam int DEF_PRICE_W     = 8;
  localparam int DEF_UPPER_BOUND = 100;
  localparam int DEF_LOWER_BOUND = 20;
  localparam int DEF_STEP_BITS   = 3;

  function automatic int init_price(input int lo, input int hi);
    return (lo + hi) / 2;
  endfunction

endpackage

// File: rtl/price_step.sv
// price_step: purely combinational bounded price step.
//   price     in  PRICE_W    current price
//   delta     in  STEP_BITS  step magnitude
//   dir       in  1          0 = up, 1 = down
//   new_price out PRICE_W    stepped price clamped to [LOWER_BOUND, UPPER_BOUND]
//   clamped   out 1          high when the clamp changed the raw result
module price_step
  import market_pkg::*;
#(
  parameter int PRICE_W     = DEF_PRICE_W,
  parameter int STEP_BITS   = DEF_STEP_BITS,
  parameter int UPPER_BOUND = DEF_UPPER_BOUND,
  parameter int LOWER_BOUND = DEF_LOWER_BOUND
) (
  input  logic [PRICE_W-1:0]   price,
  input  logic [STEP_BITS-1:0] delta,
  input  logic                 dir,
  output logic [PRICE_W-1:0]   new_price,
  output logic                 clamped
);

  localparam logic [PRICE_W:0] HI = (PRICE_W+1)'(UPPER_BOUND);
  localparam logic [PRICE_W:0] LO = (PRICE_W+1)'(LOWER_BOUND);

  logic [PRICE_W:0] ext_price;
  logic [PRICE_W:0] ext_delta;
  logic [PRICE_W:0] raw;
  logic             underflow;

  // The extra top bit keeps an upward step from wrapping; a downward step
  // that would go negative is caught explicitly as underflow.
  always_comb begin
    ext_price = {1'b0, price};
    ext_delta = (PRICE_W+1)'(delta);
    underflow = 1'b0;
    raw       = ext_price + ext_delta;
    if (dir) begin
      underflow = (ext_price < ext_delta);
      raw       = ext_price - ext_delta;
    end
    new_price = raw[PRICE_W-1:0];
    clamped   = 1'b0;
    if (underflow || (raw < LO)) begin
      new_price = LO[PRICE_W-1:0];
      clamped   = 1'b1;
    end else if (raw > HI) begin
      new_price = HI[PRICE_W-1:0];
      clamped   = 1'b1;
    end
  end

endmodule

// File: rtl/market_update_scheduler.sv
// market_update_scheduler: each tick starts one round-robin sweep over the
// stock bank; every stock fetches one random byte and takes a bounded step.
//   clock_50    in   rising-edge clock
//   reset       in   synchronous, active-low reset
//   tick        in   sweep-start pulse; a tick while busy is dropped (overrun)
//   rng_req     out  random value request (high in every REQ cycle)
//   rng_ack     in   rng_value valid this cycle
//   rng_value   in   random byte
//   sel         in   price read select
//   price_out   out  price[sel], combinational
//   update_idx  out  stock being processed
//   update_done out  one-cycle pulse in the cycle price[update_idx] is written
//   busy        out  FSM not idle
//   overrun     out  sticky dropped-tick flag, cleared only by reset
//   state       out  current FSM state (debug visibility)
// Optional feature macro: MARKET_TREND_EN adds a per-stock trend bit that
// sets the step direction instead of rng_value[7].
//
// Handshake: a random byte is transferred on a rising edge where rng_req and
// rng_ack are both high. rng_req rises on entering REQ, stays high until that
// transfer edge, and is low from the next cycle. rng_ack in any other cycle
// is ignored.
module market_update_scheduler
  import market_pkg::*;
#(
  parameter int NUM_STOCKS  = DEF_NUM_STOCKS,
  parameter int PRICE_W     = DEF_PRICE_W,
  parameter int UPPER_BOUND = DEF_UPPER_BOUND,
  parameter int LOWER_BOUND = DEF_LOWER_BOUND,
  parameter int STEP_BITS   = DEF_STEP_BITS
) (
  input  logic                          clock_50,
  input  logic                          reset,
  input  logic                          tick,
  output logic                          rng_req,
  input  logic                          rng_ack,
  input  logic [7:0]                    rng_value,
  input  logic [$clog2(NUM_STOCKS)-1:0] sel,
  output logic [PRICE_W-1:0]            price_out,
  output logic [$clog2(NUM_STOCKS)-1:0] update_idx,
  output logic                          update_done,
  output logic                          busy,
  output logic                          overrun,
  output state_t                        state
);

  localparam int                  IDX_W    = $clog2(NUM_STOCKS);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_STOCKS - 1);
  localparam logic [PRICE_W-1:0]  INIT     = PRICE_W'(init_price(LOWER_BOUND, UPPER_BOUND));

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q;
  logic [STEP_BITS-1:0] delta_q;
  logic [PRICE_W-1:0]   result_q;
  logic                 overrun_q;
  logic [PRICE_W-1:0]   bank [NUM_STOCKS];

  logic                 step_dir;
  logic [PRICE_W-1:0]   step_price;
  logic                 step_clamped;
  logic                 unused_bits;

`ifdef MARKET_TREND_EN
  logic [NUM_STOCKS-1:0] trend_q;
  logic                  flip_q;     // captured byte[7:6] == 2'b11
  logic                  clamped_q;
  assign step_dir    = trend_q[idx_q];
  assign unused_bits = ^rng_value;
`else
  logic                  dir_q;
  assign step_dir    = dir_q;
  assign unused_bits = ^{rng_value, step_clamped};
`endif

  price_step #(
    .PRICE_W     (PRICE_W),
    .STEP_BITS   (STEP_BITS),
    .UPPER_BOUND (UPPER_BOUND),
    .LOWER_BOUND (LOWER_BOUND)
  ) u_price_step (
    .price     (bank[idx_q]),
    .delta     (delta_q),
    .dir       (step_dir),
    .new_price (step_price),
    .clamped   (step_clamped)
  );

  // FSM state register
  always_ff @(posedge clock_50) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = REQ;
      REQ:     if (rng_ack) state_d = CALC;
      CALC:    state_d = WRITE;
      WRITE:   state_d = (idx_q == LAST_IDX) ? IDLE : REQ;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: index, captured byte, step result, price bank, overrun flag
  always_ff @(posedge clock_50) begin
    if (!reset) begin
      idx_q     <= '0;
      delta_q   <= '0;
      result_q  <= INIT;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_STOCKS; i++) begin
        bank[i] <= INIT;
      end
`ifdef MARKET_TREND_EN
      trend_q   <= '0;
      flip_q    <= 1'b0;
      clamped_q <= 1'b0;
`else
      dir_q     <= 1'b0;
`endif
    end else begin
      // Any tick outside IDLE is dropped; the running sweep is untouched.
      if (tick && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (tick) idx_q <= '0;
        end
        REQ: begin
          if (rng_ack) begin
            delta_q <= rng_value[STEP_BITS-1:0];
`ifdef MARKET_TREND_EN
            flip_q  <= &rng_value[7:6];
`else
            dir_q   <= rng_value[7];
`endif
          end
        end
        CALC: begin
          result_q  <= step_price;
`ifdef MARKET_TREND_EN
          clamped_q <= step_clamped;
`endif
        end
        WRITE: begin
          bank[idx_q] <= result_q;
          if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
`ifdef MARKET_TREND_EN
          if (clamped_q || flip_q) trend_q[idx_q] <= ~trend_q[idx_q];
`endif
        end
        default: ;
      endcase
    end
  end

  assign rng_req     = (state_q == REQ);
  assign update_done = (state_q == WRITE);
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;
  assign update_idx  = idx_q;
  assign price_out   = bank[sel];
  assign state       = state_q;

endmodule

// File: tb/tb_market_update_scheduler.sv
// tb_market_update_scheduler: self-checking bench for market_update_scheduler.
// A per-stock price array updated with the step/clamp rules in plain integer
// arithmetic is the reference; expected written prices pass through exp_q.
module tb_market_update_scheduler;
  import market_pkg::*;

  localparam int NS = 4;
  localparam int PW = 8;
  localparam int UB = 100;
  localparam int LB = 20;
  localparam int SB = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          tick;
  logic          rng_req;
  logic          rng_ack;
  logic [7:0]    rng_value;
  logic [1:0]    sel;
  logic [PW-1:0] price_out;
  logic [1:0]    update_idx;
  logic          update_done;
  logic          busy;
  logic          overrun;
  state_t        dut_state;

  market_update_scheduler dut (
    .clock_50    (clk),
    .reset       (reset),
    .tick        (tick),
    .rng_req     (rng_req),
    .rng_ack     (rng_ack),
    .rng_value   (rng_value),
    .sel         (sel),
    .price_out   (price_out),
    .update_idx  (update_idx),
    .update_done (update_done),
    .busy        (busy),
    .overrun     (overrun),
    .state       (dut_state)
  );

  int checks = 0;
  int errors = 0;
  int model [NS];
  logic [PW-1:0] exp_q [$];

  // Reference step: signed integer arithmetic, then clamp to the legal range.
  function automatic int ref_step(input int p, input logic [7:0] b);
    int d;
    int r;
    d = int'(b) % (1 << SB);
    r = b[7] ? (p - d) : (p + d);
    if (r > UB) r = UB;
    if (r < LB) r = LB;
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b0; tick = 1'b0; rng_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NS; i++) model[i] = (LB + UB) / 2;
    exp_q.delete();
  endtask

  // One sweep. wait_mode < 0 picks a random ack delay per stock, otherwise a
  // fixed delay. extra_tick fires a tick in stock 0's CALC cycle. reset_at
  // (>= 0) asserts reset in that stock's CALC cycle and ends the sweep.
  task automatic run_sweep(input logic [31:0] vals, input int wait_mode,
                           input bit extra_tick, input int reset_at);
    int nwait;
    logic [PW-1:0] exp_p;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    for (int s = 0; s < NS; s++) begin
      rng_ack = 1'b0;
      nwait = (wait_mode < 0) ? $urandom_range(0, 3) : wait_mode;
      sel = 2'(s);
      for (int w = 0; w < nwait; w++) begin
        #1;
        checks++;
        if (rng_req !== 1'b1 || update_done !== 1'b0 || price_out !== PW'(model[s])) begin
          errors++;
          $display("FAIL ack_wait stock=%0d req=%b done=%b price=%0d exp req=1 done=0 price=%0d",
                   s, rng_req, update_done, price_out, model[s]);
        end
        @(negedge clk);
      end
      checks++;
      if (rng_req !== 1'b1 || update_idx !== 2'(s) || busy !== 1'b1) begin
        errors++;
        $display("FAIL req_cycle stock=%0d req=%b idx=%0d busy=%b exp 1/%0d/1",
                 s, rng_req, update_idx, busy, s);
      end
      rng_ack = 1'b1;
      rng_value = vals[s*8 +: 8];
      @(negedge clk);
      // CALC cycle: request dropped; ack noise must be ignored
      checks++;
      if (rng_req !== 1'b0 || update_done !== 1'b0) begin
        errors++;
        $display("FAIL calc_cycle stock=%0d req=%b done=%b exp 0/0", s, rng_req, update_done);
      end
      if (reset_at == s) begin
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < NS; i++) model[i] = (LB + UB) / 2;
        checks++;
        if (dut_state !== IDLE || rng_req !== 1'b0 || busy !== 1'b0 ||
            overrun !== 1'b0 || update_done !== 1'b0 || update_idx !== 2'd0) begin
          errors++;
          $display("FAIL reset_mid state=%0d req=%b busy=%b ovr=%b done=%b idx=%0d exp IDLE/0/0/0/0/0",
                   dut_state, rng_req, busy, overrun, update_done, update_idx);
        end
        for (int i = 0; i < NS; i++) begin
          sel = 2'(i);
          #1;
          checks++;
          if (price_out !== 8'd60) begin
            errors++;
            $display("FAIL reset_mid_price stock=%0d got=%0d exp=60", i, price_out);
          end
        end
        return;
      end
      if (extra_tick && s == 0) tick = 1'b1;
      rng_ack = 1'($urandom_range(0, 1));
      rng_value = 8'($urandom);
      @(negedge clk);
      tick = 1'b0;
      // WRITE cycle
      checks++;
      if (update_done !== 1'b1 || update_idx !== 2'(s)) begin
        errors++;
        $display("FAIL write_cycle stock=%0d done=%b idx=%0d exp 1/%0d", s, update_done, update_idx, s);
      end
      model[s] = ref_step(model[s], vals[s*8 +: 8]);
      exp_q.push_back(PW'(model[s]));
      rng_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      rng_ack = 1'b0;
      sel = 2'(s);
      #1;
      exp_p = exp_q.pop_front();
      checks++;
      if (price_out !== exp_p) begin
        errors++;
        $display("FAIL price_written stock=%0d got=%0d exp=%0d", s, price_out, exp_p);
      end
      checks++;
      if ((s == NS-1) ? (busy !== 1'b0 || update_done !== 1'b0) : (rng_req !== 1'b1)) begin
        errors++;
        $display("FAIL after_write stock=%0d busy=%b req=%b done=%b", s, busy, rng_req, update_done);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b0 || rng_req !== 1'b0 ||
        update_done !== 1'b0 || update_idx !== 2'd0 || dut_state !== IDLE) begin
      errors++;
      $display("FAIL reset_outputs busy=%b ovr=%b req=%b done=%b idx=%0d state=%0d exp 0/0/0/0/0/IDLE",
               busy, overrun, rng_req, update_done, update_idx, dut_state);
    end
    for (int i = 0; i < NS; i++) begin
      sel = 2'(i);
      #1;
      checks++;
      if (price_out !== 8'd60) begin
        errors++;
        $display("FAIL reset_price stock=%0d got=%0d exp=60", i, price_out);
      end
    end
  endtask

  task automatic test_fixed_step();
    run_sweep(32'h05050505, 0, 1'b0, -1);
    sel = 2'd0;
    #1;
    checks++;
    if (price_out !== 8'd65) begin
      errors++;
      $display("FAIL fixed_step stock=0 got=%0d exp=65", price_out);
    end
  endtask

  task automatic test_clamp();
    do_reset();
    @(negedge clk);
    // byte order: stock0 in [7:0] ... stock3 in [31:24]
    for (int k = 0; k < 5; k++) run_sweep(32'h85058707, -1, 1'b0, -1);
    run_sweep(32'h80008303, -1, 1'b0, -1);
    run_sweep(32'h85058707, -1, 1'b0, -1);
    sel = 2'd0;
    #1;
    checks++;
    if (price_out !== 8'd100) begin
      errors++;
      $display("FAIL clamp_high got=%0d exp=100", price_out);
    end
    sel = 2'd1;
    #1;
    checks++;
    if (price_out !== 8'd20) begin
      errors++;
      $display("FAIL clamp_low got=%0d exp=20", price_out);
    end
  endtask

  task automatic test_ack_hold();
    run_sweep({$urandom}, 5, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) run_sweep({$urandom}, -1, 1'b0, -1);
  endtask

  task automatic test_overrun();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_pre got=%b exp=0", overrun);
    end
    run_sweep({$urandom}, 0, 1'b1, -1);
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (overrun !== 1'b1 || busy !== 1'b0 || update_done !== 1'b0) begin
        errors++;
        $display("FAIL overrun_idle cycle=%0d ovr=%b busy=%b done=%b exp 1/0/0",
                 c, overrun, busy, update_done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    run_sweep({$urandom}, -1, 1'b0, 2);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rng_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after busy=%b req=%b exp 0/0", busy, rng_req);
    end
    run_sweep({$urandom}, -1, 1'b0, -1);
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; rng_ack = 1'b0; rng_value = 8'h00; sel = 2'd0;
    test_reset();
    test_fixed_step();
    test_clamp();
    test_ack_hold();
    test_random();
    test_overrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
